td4_regfile: RTL and testbench
==============================

# td4_regfile

Parametrised register file for the TD4 datapath. Holds NREG general-purpose registers, the output-port register, the program counter and the carry flag, all loaded from one shared data bus under active-low per-destination load enables. The PC increments every cycle unless it is loaded or the file is stalled. Sits between the instruction decoder (LOAD, STALL) and the ALU/ROM (register outputs, ADDRESS).

## Interface

Parameters:
- DATA_W, 4, width of general registers, output port and IN_DATA
- NREG, 2, number of general registers (≥1); index 0 = A, 1 = B
- ADDR_W, 4, program counter width

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- STALL  input  1  high: hold all state; LOAD and CARRY_IN ignored
- LOAD  input  NREG+2  active-low load enables: bit i<NREG = general reg i, bit NREG = output port, bit NREG+1 = PC
- IN_DATA  input  DATA_W  shared write data (ALU result)
- CARRY_IN  input  1  ALU carry for this cycle
- OUT_REG  output  NREG*DATA_W  flattened general registers, reg i at [i*DATA_W +: DATA_W]
- OUT_PORT  output  DATA_W  output-port register
- ADDRESS  output  ADDR_W  program counter
- CARRY  output  1  carry flag register
- WRAP  output  1  one-cycle pulse: PC incremented from all-ones to zero

## Operation

- All state is register-based; all outputs come directly from flops; no combinational input-to-output path.
- Reset (RST low, asynchronous): every general reg, OUT_PORT, ADDRESS = 0; CARRY = 0; WRAP = 0. Reset asserted mid-operation clears state immediately, regardless of clock. The first active edge after RST releases performs a normal update.
- Per rising edge with STALL=0:
  - General reg i: if LOAD[i]=0, load IN_DATA; else hold.
  - OUT_PORT: if LOAD[NREG]=0, load IN_DATA; else hold.
  - PC: if LOAD[NREG+1]=0, load IN_DATA zero-extended (ADDR_W>DATA_W) or truncated to low ADDR_W bits (ADDR_W<DATA_W); else PC+1 modulo 2^ADDR_W.
  - CARRY: loaded from CARRY_IN every unstalled cycle (TD4 semantics: flag reflects the last executed instruction).
  - WRAP: 1 only when the PC increments (no load) from 2^ADDR_W−1 to 0; otherwise 0. A load to 0 does not set WRAP.
- Multiple LOAD bits low in the same cycle: every selected destination loads the same IN_DATA; legal, no priority.
- All LOAD bits high: no register writes, PC increments.
- STALL=1: all registers, PC and CARRY hold; WRAP = 0. STALL takes precedence over LOAD.
- LOAD bits X/Z are not handled; the decoder guarantees known values after reset.

## Timing

- Load latency: 1 cycle; value on IN_DATA at edge N appears on the output after edge N.
- PC sequence without loads: 0,1,2,…,2^ADDR_W−1,0 with WRAP high for exactly the cycle after the wrap edge.
- CARRY_IN sampled same edge as IN_DATA; conditional-jump decisions use CARRY (previous instruction's carry).
- No handshakes; single-cycle throughput, one update per unstalled clock.

## Structure

- Shared package td4_pkg: default DATA_W/ADDR_W/NREG, constants LD_A=0, LD_B=1, and functions giving the port/PC bit indices LD_OUT(NREG)=NREG, LD_PC(NREG)=NREG+1.
- Sub-module td4_pc: ADDR_W-bit counter with load, stall and wrap pulse; instantiated once. General registers and OUT_PORT built with a generate loop in td4_regfile.

## Test plan

- Reset: drive state non-zero, assert RST low between edges → all outputs 0 immediately, WRAP 0; release → PC counts 0,1,2.
- Load A then B (defaults): IN_DATA=4'b1010, LOAD=4'b1110 → A=1010 next cycle; IN_DATA=4'b0101, LOAD=4'b1101 → B=0101, A unchanged, PC advanced by 2 total.
- Multi-load: IN_DATA=4'b0111, LOAD=4'b0010 (A and PC... bits 0,2,3 low) → A=0111, OUT_PORT=0111, ADDRESS=0111, B holds.
- Wrap: let PC free-run from 0 → after 15 increments ADDRESS=15, next edge ADDRESS=0 and WRAP=1 for one cycle; jump to 0 via LOAD[3]=0 → WRAP stays 0.
- Stall: STALL=1 with LOAD=4'b0000, CARRY_IN=1 for 3 cycles → all outputs unchanged, CARRY unchanged, WRAP 0; deassert → update resumes next edge.
- Parameter sweep: DATA_W=8, NREG=4, ADDR_W=6 → reg 3 at OUT_REG[31:24] loads 8'hA5 via LOAD bit 3; PC load of 8'hFF truncates to ADDRESS=6'h3F; PC wraps after 63.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared defaults and LOAD-vector bit positions for the TD4 register file.
package td4_pkg;

  localparam int unsigned TD4_DATA_W = 4;
  localparam int unsigned TD4_ADDR_W = 4;
  localparam int unsigned TD4_NREG   = 2;

  localparam int unsigned LD_A = 0;
  localparam int unsigned LD_B = 1;

  // Output-port and PC enables sit directly above the general registers.
  function automatic int unsigned ld_out(input int unsigned nreg);
    return nreg;
  endfunction

  function automatic int unsigned ld_pc(input int unsigned nreg);
    return nreg + 1;
  endfunction

endpackage : td4_pkg

// File: rtl/td4_pc.sv
// TD4 program counter: loadable, stallable, free-running counter with a
// one-cycle pulse when it rolls over from all-ones to zero.
module td4_pc #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              load_n,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  logic [ADDR_W-1:0] pc_next_c;
  logic              wrap_next_c;

  // Next PC: a load takes the bus value (width-adjusted); otherwise count up.
  always_comb begin
    pc_next_c   = pc;
    wrap_next_c = 1'b0;
    if (!stall) begin
      if (!load_n) begin
        pc_next_c = ADDR_W'(load_data);
      end else begin
        pc_next_c   = pc + ADDR_W'(1);
        wrap_next_c = &pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      pc   <= pc_next_c;
      wrap <= wrap_next_c;
    end
  end

endmodule : td4_pc

// File: rtl/td4_regfile.sv
// TD4 register file: general registers, output port, carry flag and PC,
// all written from one shared bus under active-low per-destination enables.
module td4_regfile
  import td4_pkg::*;
#(
  parameter int unsigned DATA_W = TD4_DATA_W,
  parameter int unsigned NREG   = TD4_NREG,
  parameter int unsigned ADDR_W = TD4_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   STALL,
  input  logic [NREG+1:0]        LOAD,
  input  logic [DATA_W-1:0]      IN_DATA,
  input  logic                   CARRY_IN,
  output logic [NREG*DATA_W-1:0] OUT_REG,
  output logic [DATA_W-1:0]      OUT_PORT,
  output logic [ADDR_W-1:0]      ADDRESS,
  output logic                   CARRY,
  output logic                   WRAP
);

  localparam int unsigned LD_OUT_IDX = ld_out(NREG);
  localparam int unsigned LD_PC_IDX  = ld_pc(NREG);

  logic [DATA_W-1:0] gpr_q [NREG];

  // One enable-gated register per general-purpose slot.
  for (genvar i = 0; i < NREG; i++) begin : g_gpr
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        gpr_q[i] <= '0;
      end else if (!STALL && !LOAD[i]) begin
        gpr_q[i] <= IN_DATA;
      end
    end

    assign OUT_REG[i*DATA_W +: DATA_W] = gpr_q[i];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_PORT <= '0;
    end else if (!STALL && !LOAD[LD_OUT_IDX]) begin
      OUT_PORT <= IN_DATA;
    end
  end

  // Carry reflects the most recent executed instruction, so it follows
  // CARRY_IN on every unstalled edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CARRY <= 1'b0;
    end else if (!STALL) begin
      CARRY <= CARRY_IN;
    end
  end

  td4_pc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc (
    .clk       (CLK),
    .rst_n     (RST),
    .stall     (STALL),
    .load_n    (LOAD[LD_PC_IDX]),
    .load_data (IN_DATA),
    .pc        (ADDRESS),
    .wrap      (WRAP)
  );

endmodule : td4_regfile

// File: tb/tb_td4_regfile.sv
// Self-checking bench for td4_regfile: default build plus an 8/4/6 build.
module tb_td4_regfile;
  import td4_pkg::*;

  logic clk;
  logic rst;

  logic        stall0, cin0;
  logic [3:0]  load0, data0;
  logic [7:0]  oreg0;
  logic [3:0]  oport0, addr0;
  logic        car0, wrap0;

  logic        stall1, cin1;
  logic [5:0]  load1;
  logic [7:0]  data1;
  logic [31:0] oreg1;
  logic [7:0]  oport1;
  logic [5:0]  addr1;
  logic        car1, wrap1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: [dut][reg]
  int mreg [2][4];
  int mport [2];
  int mpc   [2];
  int mcar  [2];
  int mwrap [2];

  td4_regfile u_dut0 (
    .CLK(clk), .RST(rst), .STALL(stall0), .LOAD(load0), .IN_DATA(data0),
    .CARRY_IN(cin0), .OUT_REG(oreg0), .OUT_PORT(oport0), .ADDRESS(addr0),
    .CARRY(car0), .WRAP(wrap0)
  );

  td4_regfile #(.DATA_W(8), .NREG(4), .ADDR_W(6)) u_dut1 (
    .CLK(clk), .RST(rst), .STALL(stall1), .LOAD(load1), .IN_DATA(data1),
    .CARRY_IN(cin1), .OUT_REG(oreg1), .OUT_PORT(oport1), .ADDRESS(addr1),
    .CARRY(car1), .WRAP(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) mreg[d][i] = 0;
      mport[d] = 0; mpc[d] = 0; mcar[d] = 0; mwrap[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic st, input logic [5:0] ld,
                            input int dat, input logic ci);
    int nr;
    int aw;
    nr = (d == 1) ? 4 : 2;
    aw = (d == 1) ? 6 : 4;
    if (st) begin
      mwrap[d] = 0;
    end else begin
      for (int i = 0; i < nr; i++) if (!ld[i]) mreg[d][i] = dat;
      if (!ld[nr]) mport[d] = dat;
      if (!ld[nr+1]) begin
        mpc[d]   = dat % (1 << aw);
        mwrap[d] = 0;
      end else begin
        mwrap[d] = (mpc[d] == (1 << aw) - 1) ? 1 : 0;
        mpc[d]   = (mpc[d] + 1) % (1 << aw);
      end
      mcar[d] = int'(ci);
    end
  endtask

  function automatic logic [17:0] exp0();
    return {4'(mreg[0][1]), 4'(mreg[0][0]), 4'(mport[0]), 4'(mpc[0]),
            1'(mcar[0]), 1'(mwrap[0])};
  endfunction

  function automatic logic [47:0] exp1();
    return {8'(mreg[1][3]), 8'(mreg[1][2]), 8'(mreg[1][1]), 8'(mreg[1][0]),
            8'(mport[1]), 6'(mpc[1]), 1'(mcar[1]), 1'(mwrap[1])};
  endfunction

  // One clock: both DUTs and the model see the currently driven inputs.
  task automatic tick();
    @(posedge clk);
    model_step(0, stall0, {2'b00, load0}, int'(data0), cin0);
    model_step(1, stall1, load1, int'(data1), cin1);
    #1;
  endtask

  task automatic idle_inputs();
    stall0 = 1'b0; load0 = 4'hF; data0 = 4'h0; cin0 = 1'b0;
    stall1 = 1'b0; load1 = 6'h3F; data1 = 8'h00; cin1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    n_checks++;
    if ({oreg0, oport0, addr0, car0, wrap0} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_init0: got %h expected 0", {oreg0, oport0, addr0, car0, wrap0});
    end
    n_checks++;
    if ({oreg1, oport1, addr1, car1, wrap1} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_init1: got %h expected 0", {oreg1, oport1, addr1, car1, wrap1});
    end
    #10 rst = 1'b1;
    load0 = 4'h0; data0 = 4'hF; cin0 = 1'b1;
    load1 = 6'h00; data1 = 8'hFF; cin1 = 1'b1;
    tick();
    n_checks++;
    if ({oreg0, oport0, addr0, car0, wrap0} !== exp0()) begin
      n_fail++;
      $display("FAIL reset_fill0: got %h expected %h", {oreg0, oport0, addr0, car0, wrap0}, exp0());
    end
    // Asynchronous assertion between edges must clear immediately.
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({oreg0, oport0, addr0, car0, wrap0} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_async0: got %h expected 0", {oreg0, oport0, addr0, car0, wrap0});
    end
    n_checks++;
    if ({oreg1, oport1, addr1, car1, wrap1} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_async1: got %h expected 0", {oreg1, oport1, addr1, car1, wrap1});
    end
    #1 rst = 1'b1;
    idle_inputs();
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks++;
      if (addr0 !== 4'(k) || wrap0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pc_count: got pc=%0d wrap=%b expected pc=%0d wrap=0", addr0, wrap0, k);
      end
    end
  endtask

  task automatic test_load_ab();
    data0 = 4'b1010; load0 = 4'hF; load0[LD_A] = 1'b0;
    tick();
    n_checks++;
    if (oreg0[3:0] !== 4'b1010 || addr0 !== 4'd3) begin
      n_fail++;
      $display("FAIL load_a: got A=%b pc=%0d expected A=1010 pc=3", oreg0[3:0], addr0);
    end
    data0 = 4'b0101; load0 = 4'hF; load0[LD_B] = 1'b0;
    tick();
    n_checks++;
    if (oreg0 !== 8'b0101_1010 || addr0 !== 4'd4 || oport0 !== 4'h0) begin
      n_fail++;
      $display("FAIL load_b: got regs=%b port=%h pc=%0d expected regs=01011010 port=0 pc=4",
               oreg0, oport0, addr0);
    end
  endtask

  task automatic test_multi_load();
    data0 = 4'b0111; load0 = 4'b0010;
    tick();
    n_checks++;
    if (oreg0 !== 8'b0101_0111 || oport0 !== 4'b0111 || addr0 !== 4'b0111 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_load: got regs=%b port=%b pc=%b wrap=%b expected 01010111/0111/0111/0",
               oreg0, oport0, addr0, wrap0);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    data0 = 4'h0; load0 = 4'b0111;
    tick();
    load0 = 4'hF;
    for (int k = 1; k <= 15; k++) tick();
    n_checks++;
    if (addr0 !== 4'd15 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_top: got pc=%0d wrap=%b expected pc=15 wrap=0", addr0, wrap0);
    end
    tick();
    n_checks++;
    if (addr0 !== 4'd0 || wrap0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse: got pc=%0d wrap=%b expected pc=0 wrap=1", addr0, wrap0);
    end
    tick();
    n_checks++;
    if (addr0 !== 4'd1 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_single: got pc=%0d wrap=%b expected pc=1 wrap=0", addr0, wrap0);
    end
    for (int k = 2; k <= 15; k++) tick();
    load0 = 4'b0111; data0 = 4'h0;
    tick();
    n_checks++;
    if (addr0 !== 4'd0 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_jump0: got pc=%0d wrap=%b expected pc=0 wrap=0", addr0, wrap0);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [17:0] held0;
    logic [47:0] held1;
    tick();
    held0 = exp0();
    held0[0] = 1'b0;
    held1 = exp1();
    held1[0] = 1'b0;
    stall0 = 1'b1; load0 = 4'h0; cin0 = 1'b1; data0 = 4'hC;
    stall1 = 1'b1; load1 = 6'h00; cin1 = 1'b1; data1 = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({oreg0, oport0, addr0, car0, wrap0} !== held0) begin
        n_fail++;
        $display("FAIL stall_hold0: got %h expected %h", {oreg0, oport0, addr0, car0, wrap0}, held0);
      end
      n_checks++;
      if ({oreg1, oport1, addr1, car1, wrap1} !== held1) begin
        n_fail++;
        $display("FAIL stall_hold1: got %h expected %h", {oreg1, oport1, addr1, car1, wrap1}, held1);
      end
    end
    stall0 = 1'b0; stall1 = 1'b0;
    tick();
    n_checks++;
    if ({oreg0, oport0, addr0, car0, wrap0} !== 18'b1100_1100_1100_1100_1_0) begin
      n_fail++;
      $display("FAIL stall_resume: got %h expected %h",
               {oreg0, oport0, addr0, car0, wrap0}, 18'b1100_1100_1100_1100_1_0);
    end
    idle_inputs();
  endtask

  task automatic test_param_sweep();
    data1 = 8'hA5; load1 = 6'b110111;
    tick();
    n_checks++;
    if (oreg1[31:24] !== 8'hA5 || oreg1[23:0] !== 24'h3C3C3C) begin
      n_fail++;
      $display("FAIL sweep_reg3: got %h expected a53c3c3c", oreg1);
    end
    data1 = 8'hFF; load1 = 6'b011111;
    tick();
    n_checks++;
    if (addr1 !== 6'h3F || wrap1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_pc_trunc: got pc=%h wrap=%b expected pc=3f wrap=0", addr1, wrap1);
    end
    load1 = 6'h3F;
    tick();
    n_checks++;
    if (addr1 !== 6'h00 || wrap1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_wrap: got pc=%h wrap=%b expected pc=00 wrap=1", addr1, wrap1);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      stall0 = ($urandom_range(7) == 0);
      load0  = 4'($urandom);
      data0  = 4'($urandom);
      cin0   = 1'($urandom);
      stall1 = ($urandom_range(7) == 0);
      load1  = 6'($urandom) | ((k % 3 != 0) ? 6'h20 : 6'h00);
      data1  = 8'($urandom);
      cin1   = 1'($urandom);
      tick();
      n_checks++;
      if ({oreg0, oport0, addr0, car0, wrap0} !== exp0()) begin
        n_fail++;
        $display("FAIL random0 cycle %0d: got %h expected %h", k,
                 {oreg0, oport0, addr0, car0, wrap0}, exp0());
      end
      n_checks++;
      if ({oreg1, oport1, addr1, car1, wrap1} !== exp1()) begin
        n_fail++;
        $display("FAIL random1 cycle %0d: got %h expected %h", k,
                 {oreg1, oport1, addr1, car1, wrap1}, exp1());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_ab();
    test_multi_load();
    test_wrap();
    test_stall();
    test_param_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_td4_regfile
